// File: rtl/paint_pkg.sv
// paint_pkg: shared types and default canvas constants for the brush painter.
//   color_t        3-bit pixel colour
//   paint_cmd_t    one queued brush command {x, y, color}
//   paint_state_t  stamping FSM states
package paint_pkg;

  localparam int DEF_WIDTH   = 160;
  localparam int DEF_HEIGHT  = 120;
  localparam int DEF_ADDR_W  = 15;
  localparam int DEF_BRUSH_R = 1;
  localparam int DEF_FIFO_D  = 4;

  typedef logic [2:0] color_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    color_t     color;
  } paint_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAINT
  } paint_state_t;

endpackage

// File: rtl/paint_cmd_fifo.sv
// paint_cmd_fifo: synchronous FIFO of paint commands.
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset (empties the FIFO)
//   push   write din when not full (a push while full is ignored; a pop in the
//          same cycle does not make room for it)
//   din    command to enqueue
//   pop    advance the read pointer when not empty
//   dout   oldest command (valid while !empty)
//   full   DEPTH entries held
//   empty  no entries held
module paint_cmd_fifo
  import paint_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  paint_cmd_t din,
  input  logic       pop,
  output paint_cmd_t dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = (PW + 1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  paint_cmd_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers alone, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/paint_scheduler.sv
// paint_scheduler: queues SPI brush commands and stamps a clipped square brush
// of side 2*BRUSH_R+1 into the single-port frame buffer, one pixel per cycle.
// The VGA read path owns the port whenever it asks for it.
// Ports:
//   clk, reset       system clock, synchronous active-low reset
//   brushUpdate,x,y  1-cycle strobe enqueueing a brush at (x,y)
//   newColorUpdate   colour loaded on updateConfig
//   updateConfig     1-cycle strobe: latch newColorUpdate as current colour
//   vgaRdReq,vgaAddr VGA port request and read address
//   fbAddr,fbWe,fbWData  frame-buffer port
//   busy             FIFO non-empty or stamp in progress
//   cmdDropped       1-cycle pulse after a brushUpdate hit a full FIFO
module paint_scheduler
  import paint_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BRUSH_R = DEF_BRUSH_R,
  parameter int FIFO_D  = DEF_FIFO_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              brushUpdate,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [2:0]        newColorUpdate,
  input  logic              updateConfig,
  input  logic              vgaRdReq,
  input  logic [ADDR_W-1:0] vgaAddr,
  output logic [ADDR_W-1:0] fbAddr,
  output logic              fbWe,
  output logic [2:0]        fbWData,
  output logic              busy,
  output logic              cmdDropped
);

  localparam logic signed [9:0]  R_S = 10'(BRUSH_R);
  localparam logic signed [9:0]  W_S = 10'(WIDTH);
  localparam logic signed [9:0]  H_S = 10'(HEIGHT);
  localparam logic [ADDR_W-1:0]  W_A = ADDR_W'(WIDTH);

  paint_state_t      state_q, state_d;
  color_t            color_q;
  paint_cmd_t        cmd_q;
  paint_cmd_t        push_cmd;
  paint_cmd_t        fifo_dout;
  logic              fifo_full, fifo_empty;
  logic              pop;
  logic              cmd_dropped_q;
  logic signed [9:0] dx, dy;
  logic signed [9:0] px, py, py0;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] pix_addr;
  logic              in_canvas;
  logic              last_pix;
  logic              paint_wr;

  // A colour update coinciding with a brush strobe applies to that brush.
  assign push_cmd = '{x: x, y: y,
                      color: (updateConfig ? newColorUpdate : color_q)};

  paint_cmd_fifo #(.DEPTH(FIFO_D)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (brushUpdate),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Current pixel in signed 10-bit so clipping on all four edges is a compare.
  assign px        = $signed({2'b00, cmd_q.x}) + dx;
  assign py        = $signed({2'b00, cmd_q.y}) + dy;
  assign py0       = $signed({2'b00, cmd_q.y}) - R_S;
  assign in_canvas = !px[9] && (px < W_S) && !py[9] && (py < H_S);
  assign last_pix  = (dx == R_S) && (dy == R_S);

  // row_base tracks py*WIDTH modulo 2**ADDR_W; wrapped values for rows above
  // the canvas are harmless because such pixels are never written.
  assign pix_addr = row_base + ADDR_W'(px);

  // The whole FSM freezes while VGA owns the port, so a stalled stamp resumes
  // on the exact pixel it was holding and the FIFO is not drained meanwhile.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (!vgaRdReq) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD: state_d = PAINT;
        PAINT: begin
          if (last_pix) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    paint_wr = (state_q == PAINT) && in_canvas && !vgaRdReq;
    fbWe     = paint_wr;
    fbWData  = paint_wr ? cmd_q.color : 3'b000;
    if (vgaRdReq)      fbAddr = vgaAddr;
    else if (paint_wr) fbAddr = pix_addr;
    else               fbAddr = '0;
  end

  assign busy       = !fifo_empty || (state_q != IDLE);
  assign cmdDropped = cmd_dropped_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      color_q       <= 3'b000;
      cmd_q         <= '0;
      cmd_dropped_q <= 1'b0;
      dx            <= '0;
      dy            <= '0;
      row_base      <= '0;
    end else begin
      state_q       <= state_d;
      cmd_dropped_q <= brushUpdate && fifo_full;
      if (updateConfig) color_q <= newColorUpdate;
      if (pop)          cmd_q   <= fifo_dout;
      if (!vgaRdReq) begin
        if (state_q == LOAD) begin
          dx       <= -R_S;
          dy       <= -R_S;
          row_base <= ADDR_W'(py0) * W_A;
        end else if (state_q == PAINT) begin
          // Row-major scan: the row base steps by WIDTH instead of multiplying.
          if (dx == R_S) begin
            dx       <= -R_S;
            dy       <= dy + 10'sd1;
            row_base <= row_base + W_A;
          end else begin
            dx <= dx + 10'sd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_paint_scheduler.sv
// tb_paint_scheduler: directed scenarios plus randomized traffic, all compared
// every cycle against a queue-based model of the painter.
module tb_paint_scheduler;
  import paint_pkg::*;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int AW = 15;
  localparam int R  = 1;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          brushUpdate = 1'b0;
  logic [7:0]    x = '0;
  logic [7:0]    y = '0;
  logic [2:0]    newColorUpdate = '0;
  logic          updateConfig = 1'b0;
  logic          vgaRdReq = 1'b0;
  logic [AW-1:0] vgaAddr = '0;
  logic [AW-1:0] fbAddr;
  logic          fbWe;
  logic [2:0]    fbWData;
  logic          busy;
  logic          cmdDropped;

  always #5 clk = ~clk;

  paint_scheduler #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .BRUSH_R(R), .FIFO_D(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .brushUpdate    (brushUpdate),
    .x              (x),
    .y              (y),
    .newColorUpdate (newColorUpdate),
    .updateConfig   (updateConfig),
    .vgaRdReq       (vgaRdReq),
    .vgaAddr        (vgaAddr),
    .fbAddr         (fbAddr),
    .fbWe           (fbWe),
    .fbWData        (fbWData),
    .busy           (busy),
    .cmdDropped     (cmdDropped)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A command becomes a list of cycle steps: one load step, then one step per
  // brush pixel (write or clipped). Each cycle without a VGA request retires
  // the head step; with no steps left, the oldest queued command is expanded.
  typedef struct { int x; int y; int col; } mcmd_t;
  typedef struct { bit pix; bit wr; int addr; int col; } step_t;
  typedef struct { int addr; int data; int cyc; } wr_t;

  mcmd_t m_fifo[$];
  step_t m_steps[$];
  int    m_col;
  bit    m_drop;
  bit    m_was_full;
  bit    m_had_cmd;
  mcmd_t m_new;
  wr_t   wr_log[$];
  int    drop_seen;

  task automatic expand(input mcmd_t c);
    step_t s;
    s = '{pix: 1'b0, wr: 1'b0, addr: 0, col: 0};
    m_steps.push_back(s);
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        int px;
        int py;
        px    = c.x + dx;
        py    = c.y + dy;
        s.pix = 1'b1;
        s.wr  = (px >= 0) && (px < W) && (py >= 0) && (py < H);
        s.addr = py * W + px;
        s.col = c.col;
        m_steps.push_back(s);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_fifo.delete();
      m_steps.delete();
      m_col  = 0;
      m_drop = 1'b0;
    end else begin
      m_was_full = (m_fifo.size() >= D);
      m_had_cmd  = (m_fifo.size() > 0);
      m_new.x    = x;
      m_new.y    = y;
      m_new.col  = updateConfig ? int'(newColorUpdate) : m_col;
      if (!vgaRdReq) begin
        if (m_steps.size() > 0) void'(m_steps.pop_front());
        if (m_steps.size() == 0 && m_had_cmd) expand(m_fifo.pop_front());
      end
      if (updateConfig) m_col = newColorUpdate;
      m_drop = brushUpdate && m_was_full;
      if (brushUpdate && !m_was_full) m_fifo.push_back(m_new);
    end
  end

  // Compare process: outputs sampled mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    bit exp_we;
    int exp_addr;
    int exp_col;
    exp_we   = 1'b0;
    exp_addr = 0;
    exp_col  = 0;
    if (!vgaRdReq && m_steps.size() > 0 && m_steps[0].wr) begin
      exp_we   = 1'b1;
      exp_addr = m_steps[0].addr;
      exp_col  = m_steps[0].col;
    end
    check("fbWe", fbWe, exp_we);
    check("fbWData", fbWData, exp_col);
    check("busy", busy, (m_fifo.size() > 0) || (m_steps.size() > 0));
    check("cmdDropped", cmdDropped, m_drop);
    if (vgaRdReq)    check("fbAddr_vga", fbAddr, vgaAddr);
    else if (exp_we) check("fbAddr_paint", fbAddr, exp_addr);
    if (fbWe === 1'b1) wr_log.push_back('{addr: int'(fbAddr), data: int'(fbWData), cyc: cyc});
    if (cmdDropped === 1'b1) drop_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int bx, input int by);
    brushUpdate = 1'b1;
    x = 8'(bx);
    y = 8'(by);
    tick();
    brushUpdate = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, n < 300, 1);
  endtask

  task automatic check_addrs(input string name, input int exp[9], input int base, input int col);
    for (int i = 0; i < 9; i++) begin
      if (base + i < wr_log.size()) begin
        check({name, "_addr"}, wr_log[base + i].addr, exp[i]);
        check({name, "_data"}, wr_log[base + i].data, col);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cyc;
    int t1_exp[9];
    int t3_exp[9];
    t1_exp = '{3049, 3050, 3051, 3209, 3210, 3211, 3369, 3370, 3371};
    t3_exp = '{7889, 7890, 7891, 8049, 8050, 8051, 8209, 8210, 8211};

    // Test 1: reset, colour 101, brush (10,20).
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_we", fbWe, 0);
    reset = 1'b1;
    updateConfig = 1'b1;
    newColorUpdate = 3'b101;
    tick();
    updateConfig = 1'b0;
    wr_log.delete();
    s_cyc = cyc;
    strobe(10, 20);
    wait_idle("t1");
    check("t1_count", wr_log.size(), 9);
    check_addrs("t1", t1_exp, 0, 5);
    // Strobe sampled at edge s_cyc+1 (N); first write in the cycle after edge N+2.
    if (wr_log.size() > 0) check("t1_latency", wr_log[0].cyc - s_cyc, 3);

    // Test 2: corner brush clipped to 4 pixels.
    wr_log.delete();
    strobe(0, 0);
    wait_idle("t2");
    check("t2_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("t2_a0", wr_log[0].addr, 0);
      check("t2_a1", wr_log[1].addr, 1);
      check("t2_a2", wr_log[2].addr, 160);
      check("t2_a3", wr_log[3].addr, 161);
    end

    // Test 3: VGA steals the port for 3 cycles mid-stamp.
    wr_log.delete();
    strobe(50, 50);
    repeat (3) tick();
    vgaRdReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vgaAddr = AW'($urandom_range(0, W * H - 1));
      tick();
    end
    vgaRdReq = 1'b0;
    wait_idle("t3");
    check("t3_count", wr_log.size(), 9);
    check_addrs("t3", t3_exp, 0, 5);

    // Test 4: six strobes while VGA holds the port.
    wr_log.delete();
    drop_seen = 0;
    vgaRdReq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vgaAddr = AW'($urandom_range(0, W * H - 1));
      strobe(30 + 10 * i, 30 + 10 * i);
    end
    repeat (2) tick();
    vgaRdReq = 1'b0;
    wait_idle("t4");
    check("t4_drops", drop_seen, 2);
    check("t4_count", wr_log.size(), 36);
    if (wr_log.size() == 36) begin
      check("t4_first0", wr_log[0].addr, 4669);
      check("t4_first1", wr_log[9].addr, 6279);
      check("t4_first2", wr_log[18].addr, 7889);
      check("t4_last3", wr_log[35].addr, 9821);
    end

    // Test 5: colour update coinciding with the brush strobe.
    wr_log.delete();
    updateConfig = 1'b1;
    newColorUpdate = 3'b010;
    strobe(100, 100);
    updateConfig = 1'b0;
    wait_idle("t5");
    check("t5_count", wr_log.size(), 9);
    for (int i = 0; i < wr_log.size(); i++) check("t5_data", wr_log[i].data, 2);
    if (wr_log.size() > 0) check("t5_first", wr_log[0].addr, 15939);

    // Test 6: reset mid-stamp aborts it.
    strobe(80, 60);
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("t6_we", fbWe, 0);
    check("t6_busy", busy, 0);
    reset = 1'b1;
    wr_log.delete();
    repeat (12) tick();
    check("t6_no_writes", wr_log.size(), 0);

    // Randomized traffic, including off-canvas centres and VGA contention.
    for (int i = 0; i < 600; i++) begin
      brushUpdate    = ($urandom_range(0, 5) == 0);
      x              = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, W));
      y              = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, H));
      updateConfig   = ($urandom_range(0, 7) == 0);
      newColorUpdate = 3'($urandom_range(0, 7));
      vgaRdReq       = ($urandom_range(0, 3) == 0);
      vgaAddr        = AW'($urandom_range(0, 2 ** AW - 1));
      tick();
    end
    brushUpdate  = 1'b0;
    updateConfig = 1'b0;
    vgaRdReq     = 1'b0;
    wait_idle("rand");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
